// File: rtl/bp_pkg.sv
// bp_pkg: shared types, counter encodings and the 2-bit counter next-state function
package bp_pkg;
    typedef logic [1:0] ctr2_t;
    localparam ctr2_t CTR_SNT = 2'b00;
    localparam ctr2_t CTR_WNT = 2'b01;
    localparam ctr2_t CTR_WT  = 2'b10;
    localparam ctr2_t CTR_ST  = 2'b11;
    localparam int TAG_W_MAX = 32;
    // Tags are held zero-extended so the entry type does not depend on TAG_W
    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        ctr2_t                ctr;
        logic [31:0]          target;
    } btb_entry_t;
    function automatic ctr2_t ctr_next(ctr2_t c, logic taken);
        return taken ? ((c == CTR_ST) ? c : c + 2'd1) : ((c == CTR_SNT) ? c : c - 2'd1);
    endfunction
endpackage

// File: rtl/module_sat_counter.sv
// module_sat_counter: per-entry 2-bit saturating counter, async reset to weakly not-taken
module module_sat_counter
    import bp_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic       load_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i)
            ctr_o <= CTR_WNT;
        else if (en_i)
            ctr_o <= load_i ? CTR_WT : ctr_next(ctr_o, taken_i);
endmodule

// File: rtl/module_branch_predictor.sv
// module_branch_predictor: direct-mapped BTB with 2-bit counters, combinational lookup,
// Execute-stage training and saturating branch/mispredict statistics
module module_branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] pcf_i,
    output logic        predictionf_o,
    output logic [31:0] targetf_o,
    input  logic        update_en_i,
    input  logic [31:0] pce_i,
    input  logic        pcsrce_i,
    input  logic [31:0] pctargete_i,
    input  logic        predictione_i,
    output logic        mispredict_o,
    output logic [31:0] branch_count_o,
    output logic [31:0] mispredict_count_o
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [31:0] TAG_MASK = (32'd1 << TAG_W) - 32'd1;

    function automatic logic [IDX_W-1:0] idx_of(logic [31:0] pc);
        return IDX_W'(pc >> 2);
    endfunction

    function automatic logic [TAG_W_MAX-1:0] tag_of(logic [31:0] pc);
        return (pc >> (IDX_W + 2)) & TAG_MASK;
    endfunction

    logic                 valid_q  [ENTRIES];
    logic [TAG_W_MAX-1:0] tag_q    [ENTRIES];
    logic [31:0]          target_q [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];
    logic [31:0]          branch_cnt_q, mis_cnt_q;

    logic [IDX_W-1:0] idx_f, idx_e;
    btb_entry_t       ent_f, ent_e;
    logic             hit_f, hit_e, train_taken;

    assign idx_f = idx_of(pcf_i);
    assign idx_e = idx_of(pce_i);
    assign ent_f = '{valid: valid_q[idx_f], tag: tag_q[idx_f], ctr: ctr_q[idx_f], target: target_q[idx_f]};
    assign ent_e = '{valid: valid_q[idx_e], tag: tag_q[idx_e], ctr: ctr_q[idx_e], target: target_q[idx_e]};
    assign hit_f = ent_f.valid && (ent_f.tag == tag_of(pcf_i));
    assign hit_e = ent_e.valid && (ent_e.tag == tag_of(pce_i));

    // Lookup reads the registered arrays only, so a same-cycle update is not bypassed
    assign predictionf_o = hit_f & ent_f.ctr[1];
    assign targetf_o     = hit_f ? ent_f.target : 32'h0;

    assign train_taken        = update_en_i & pcsrce_i;
    assign mispredict_o       = update_en_i & (pcsrce_i ^ predictione_i);
    assign branch_count_o     = branch_cnt_q;
    assign mispredict_count_o = mis_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (train_taken) begin
            valid_q[idx_e]  <= 1'b1;
            tag_q[idx_e]    <= tag_of(pce_i);
            target_q[idx_e] <= pctargete_i;
        end

    // A not-taken miss leaves the entry alone; a taken miss reloads the counter to weakly taken
    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        module_sat_counter u_ctr (
            .clk_i  (clk_i),
            .rst_n_i(rst_n_i),
            .en_i   (update_en_i && (idx_e == IDX_W'(g)) && (hit_e || pcsrce_i)),
            .load_i (!hit_e),
            .taken_i(pcsrce_i),
            .ctr_o  (ctr_q[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            branch_cnt_q <= '0;
            mis_cnt_q    <= '0;
        end else begin
            if (update_en_i && branch_cnt_q != '1)
                branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mispredict_o && mis_cnt_q != '1)
                mis_cnt_q <= mis_cnt_q + 32'd1;
        end
endmodule

// File: tb/tb_module_branch_predictor.sv
// tb_module_branch_predictor: directed checks of lookup, training, aliasing, saturation and reset
module tb_module_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pcf, pce, tgt;
    logic        upd, taken, prede;
    logic        pred_f, mis;
    logic [31:0] tgt_f, br_cnt, mis_cnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    module_branch_predictor #(.ENTRIES(64), .TAG_W(8)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .pcf_i             (pcf),
        .predictionf_o     (pred_f),
        .targetf_o         (tgt_f),
        .update_en_i       (upd),
        .pce_i             (pce),
        .pcsrce_i          (taken),
        .pctargete_i       (tgt),
        .predictione_i     (prede),
        .mispredict_o      (mis),
        .branch_count_o    (br_cnt),
        .mispredict_count_o(mis_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic pe);
        pce = pc; taken = tk; tgt = tg; prede = pe; upd = 1'b1;
        tick();
        upd = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pcf = 32'h100; pce = '0; tgt = '0; upd = 1'b0; taken = 1'b0; prede = 1'b0;
        #3;
        chk("rst_pred", {31'b0, pred_f}, 32'd0);
        chk("rst_target", tgt_f, 32'h0);
        chk("rst_br_cnt", br_cnt, 32'd0);
        chk("rst_mis_cnt", mis_cnt, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("post_rst_pred", {31'b0, pred_f}, 32'd0);
        // First allocation with a same-cycle lookup of the same PC
        pce = 32'h100; taken = 1'b1; tgt = 32'h040; prede = 1'b0; upd = 1'b1;
        #1;
        chk("alloc_mispredict", {31'b0, mis}, 32'd1);
        chk("same_cycle_pred", {31'b0, pred_f}, 32'd0);
        chk("same_cycle_target", tgt_f, 32'h0);
        tick();
        upd = 1'b0;
        #1;
        chk("alloc_pred", {31'b0, pred_f}, 32'd1);
        chk("alloc_target", tgt_f, 32'h040);
        chk("alloc_mis_cnt", mis_cnt, 32'd1);
        chk("alloc_br_cnt", br_cnt, 32'd1);
        // Counter 10 -> 11 -> 11, then down 10, 01, 00, 00, then up to 01 and 10
        train(32'h100, 1'b1, 32'h040, 1'b1);
        train(32'h100, 1'b1, 32'h040, 1'b1);
        chk("sat_hi_pred", {31'b0, pred_f}, 32'd1);
        chk("no_mis_cnt", mis_cnt, 32'd1);
        train(32'h100, 1'b0, 32'h0, 1'b1);
        chk("nt1_pred_ctr10", {31'b0, pred_f}, 32'd1);
        train(32'h100, 1'b0, 32'h0, 1'b1);
        chk("nt2_pred_ctr01", {31'b0, pred_f}, 32'd0);
        chk("nt2_target_kept", tgt_f, 32'h040);
        train(32'h100, 1'b0, 32'h0, 1'b0);
        train(32'h100, 1'b0, 32'h0, 1'b0);
        chk("nt4_pred_ctr00", {31'b0, pred_f}, 32'd0);
        train(32'h100, 1'b1, 32'h044, 1'b0);
        chk("sat_lo_pred_ctr01", {31'b0, pred_f}, 32'd0);
        chk("hit_taken_target", tgt_f, 32'h044);
        train(32'h100, 1'b1, 32'h044, 1'b0);
        chk("ctr10_pred", {31'b0, pred_f}, 32'd1);
        chk("train_br_cnt", br_cnt, 32'd9);
        chk("train_mis_cnt", mis_cnt, 32'd5);
        // Alias 0x200 shares index 0 with 0x100 but has a different tag
        train(32'h200, 1'b1, 32'h200, 1'b0);
        chk("alias_evict_pred", {31'b0, pred_f}, 32'd0);
        chk("alias_evict_target", tgt_f, 32'h0);
        pcf = 32'h200;
        #1;
        chk("alias_pred", {31'b0, pred_f}, 32'd1);
        chk("alias_target", tgt_f, 32'h200);
        train(32'h100, 1'b0, 32'h0, 1'b0);
        chk("nt_miss_keeps_alias", tgt_f, 32'h200);
        chk("nt_miss_keeps_pred", {31'b0, pred_f}, 32'd1);
        train(32'h200, 1'b0, 32'h0, 1'b1);
        chk("alias_ctr_was_10", {31'b0, pred_f}, 32'd0);
        chk("alias_br_cnt", br_cnt, 32'd12);
        chk("alias_mis_cnt", mis_cnt, 32'd7);
        pcf = 32'h104;
        #1;
        chk("other_idx_miss", tgt_f, 32'h0);
        pcf = 32'h200;
        // Bubbles with taken-looking inputs change nothing
        pce = 32'h104; taken = 1'b1; tgt = 32'h999; prede = 1'b0; upd = 1'b0;
        #1;
        chk("bubble_mispredict", {31'b0, mis}, 32'd0);
        tick();
        tick();
        chk("bubble_br_cnt", br_cnt, 32'd12);
        chk("bubble_mis_cnt", mis_cnt, 32'd7);
        chk("bubble_target", tgt_f, 32'h200);
        pcf = 32'h104;
        #1;
        chk("bubble_no_alloc", tgt_f, 32'h0);
        pcf = 32'h200;
        // Statistic counters saturate at all-ones
        @(negedge clk);
        dut.branch_cnt_q <= 32'hFFFF_FFFE;
        dut.mis_cnt_q    <= 32'hFFFF_FFFE;
        #1;
        train(32'h108, 1'b0, 32'h0, 1'b1);
        chk("sat1_br_cnt", br_cnt, 32'hFFFF_FFFF);
        chk("sat1_mis_cnt", mis_cnt, 32'hFFFF_FFFF);
        train(32'h108, 1'b0, 32'h0, 1'b1);
        train(32'h108, 1'b0, 32'h0, 1'b1);
        chk("sat3_br_cnt", br_cnt, 32'hFFFF_FFFF);
        chk("sat3_mis_cnt", mis_cnt, 32'hFFFF_FFFF);
        chk("sat_alias_intact", tgt_f, 32'h200);
        // Asynchronous reset mid-operation clears everything immediately
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pred", {31'b0, pred_f}, 32'd0);
        chk("midrst_target", tgt_f, 32'h0);
        chk("midrst_br_cnt", br_cnt, 32'd0);
        chk("midrst_mis_cnt", mis_cnt, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("after_midrst_target", tgt_f, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
